// File: rtl/tea_cbc_sequencer.sv
// TEA CBC sequencer: feeds ciphertext blocks to a TEA decipher core,
// un-chains the result with the previous ciphertext and returns plaintext.
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   iIV, iIVLoad              initialisation vector and its load strobe (IDLE only)
//   iInValid/oInReady/iInData ciphertext input handshake, {V0,V1} = {[63:32],[31:0]}
//   oOutValid/iOutReady/oOutData plaintext output handshake
//   oErr                      sticky timeout flag
//   oCoreRst, oCoreV0/V1      start pulse and operands to the decipher core
//   iCoreC0/C1, iCoreDone     result and done level from the decipher core
module tea_cbc_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int TIMEOUT   = 64,
    parameter bit CBC_EN    = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*WORD_SIZE-1:0] iIV,
    input  logic                   iIVLoad,
    input  logic                   iInValid,
    output logic                   oInReady,
    input  logic [2*WORD_SIZE-1:0] iInData,
    output logic                   oOutValid,
    input  logic                   iOutReady,
    output logic [2*WORD_SIZE-1:0] oOutData,
    output logic                   oErr,
    output logic                   oCoreRst,
    output logic [WORD_SIZE-1:0]   oCoreV0,
    output logic [WORD_SIZE-1:0]   oCoreV1,
    input  logic [WORD_SIZE-1:0]   iCoreC0,
    input  logic [WORD_SIZE-1:0]   iCoreC1,
    input  logic                   iCoreDone
);

    localparam int BW = 2 * WORD_SIZE;
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_OUT
    } state_t;

    state_t state, state_nxt;

    logic [BW-1:0] chain_q;
    logic [BW-1:0] cur_q;
    logic [CW-1:0] cnt_q;
    logic          out_valid_q;
    logic [BW-1:0] out_data_q;
    logic          err_q;
    logic          core_rst_q;
    logic [BW-1:0] core_v_q;

    logic          accept;
    logic          done_ok;
    logic          tmo;
    logic [BW-1:0] chain_mask;

    // A done seen in the first WAIT cycle may still belong to the
    // previous block, so it only counts once cnt has moved off zero.
    always_comb begin
        oInReady   = rst & (state == S_IDLE) & ~iIVLoad;
        accept     = oInReady & iInValid;
        done_ok    = iCoreDone & (cnt_q != '0);
        tmo        = (cnt_q == CNT_LAST);
        chain_mask = CBC_EN ? chain_q : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (accept) state_nxt = S_START;
            S_START: state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_ok) begin
                    state_nxt = S_OUT;
                end else if (tmo) begin
                    state_nxt = S_IDLE;
                end
            end
            S_OUT:   if (iOutReady) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain_q     <= '0;
            cur_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            core_rst_q  <= 1'b0;
            core_v_q    <= '0;
        end else begin
            // High for exactly the cycle spent in START.
            core_rst_q <= (state_nxt == S_START);
            unique case (state)
                S_IDLE: begin
                    if (iIVLoad) begin
                        chain_q <= iIV;
                    end else if (accept) begin
                        core_v_q <= iInData;
                        cur_q    <= iInData;
                    end
                end
                S_START: begin
                    cnt_q <= '0;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (done_ok) begin
                        out_data_q  <= {iCoreC0, iCoreC1} ^ chain_mask;
                        chain_q     <= cur_q;
                        out_valid_q <= 1'b1;
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (iOutReady) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign oOutValid = out_valid_q;
    assign oOutData  = out_data_q;
    assign oErr      = err_q;
    assign oCoreRst  = core_rst_q;
    assign oCoreV0   = core_v_q[BW-1:WORD_SIZE];
    assign oCoreV1   = core_v_q[WORD_SIZE-1:0];

endmodule
